alu_crc_seq: RTL and testbench

ALU_CRC_SEQ -- requirements
Module: alu_crc_seq

---
 rtl/alu_crc_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_crc_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_crc_seq.sv
// ----------------------------------------------------------------------------
// AluCrcSeq (top module alu_crc_seq)
//
// Sequential CRC engine. It divides the operand by a generator polynomial,
// one bit per clock, MSB first.
//   check mode (funct=0): result is the remainder of the operand.
//   join mode  (funct=1): the operand is shifted left by R bits and divided.
//                         The remainder is appended to the low data bits.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present (only looked at in IDLE)
//   in_ready   engine can accept a request (IDLE only)
//   data       operand, DATA_W bits, consumed MSB first
//   key        generator polynomial, KEY_W bits including the x^(KEY_W-1) term
//   funct      0 = check, 1 = join
//   out_valid  result present (DONE only)
//   out_ready  consumer accepts the result (only looked at in DONE)
//   o          result, DATA_W bits
//   crc_err    check mode: remainder is nonzero
//   key_err    key rejected because its top bit is zero
// ----------------------------------------------------------------------------
module alu_crc_seq #(
   parameter int DATA_W = 32,
   parameter int KEY_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data,
   input  logic [KEY_W-1:0]  key,
   input  logic              funct,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] o,
   output logic              crc_err,
   output logic              key_err
);

   localparam int R     = KEY_W - 1;
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] LAST_PAD_BIT  = CNT_W'(R - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PAD,
      DONE
   } stateT;

   stateT             state;
   logic [R-1:0]      remReg;
   logic [CNT_W-1:0]  bitCnt;
   logic [DATA_W-1:0] dataReg;
   logic [KEY_W-1:0]  keyReg;
   logic              functReg;
   logic              inReady;
   logic              outValid;
   logic [DATA_W-1:0] resultReg;
   logic              crcErrReg;
   logic              keyErrReg;

   logic              stepBit;
   logic [KEY_W-1:0]  stepVec;
   logic [R-1:0]      nextRem;

   // One long-division step. The incoming bit is the next data bit while
   // shifting. It is zero while padding. The remainder and the incoming bit
   // form an R+1 bit window. If the top bit of the window is set, the key is
   // subtracted (XOR), which always clears that top bit. The low R bits then
   // become the new remainder. With a zero remainder, leading zero data bits
   // only shift zeros through, so the result does not depend on how many
   // leading zeros the operand has.
   always_comb begin
      stepBit = 1'b0;
      if (state == SHIFT) begin
         stepBit = dataReg[LAST_DATA_BIT - bitCnt];
      end
      stepVec = {remReg, stepBit};
      if (stepVec[R]) begin
         stepVec = stepVec ^ keyReg;
      end
      nextRem = stepVec[R-1:0];
   end

   // Control FSM and datapath registers.
   // in_ready and out_valid are registered copies of "next state is IDLE" and
   // "next state is DONE". This keeps both outputs low while reset is held.
   // in_ready rises on the first edge after reset is released.
   // A request is taken only when in_ready was already high. The DONE->IDLE
   // handshake edge therefore can never also accept a new request.
   // A bad key is detected on the first cycle after acceptance, and the FSM
   // then goes straight to DONE without dividing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remReg    <= '0;
         bitCnt    <= '0;
         dataReg   <= '0;
         keyReg    <= '0;
         functReg  <= 1'b0;
         inReady   <= 1'b0;
         outValid  <= 1'b0;
         resultReg <= '0;
         crcErrReg <= 1'b0;
         keyErrReg <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               inReady <= 1'b1;
               if (in_valid && inReady) begin
                  dataReg  <= data;
                  keyReg   <= key;
                  functReg <= funct;
                  remReg   <= '0;
                  bitCnt   <= '0;
                  inReady  <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (!keyReg[KEY_W-1]) begin
                  resultReg <= '0;
                  crcErrReg <= 1'b0;
                  keyErrReg <= 1'b1;
                  outValid  <= 1'b1;
                  state     <= DONE;
               end else begin
                  remReg <= nextRem;
                  if (bitCnt == LAST_DATA_BIT) begin
                     bitCnt <= '0;
                     if (functReg) begin
                        state <= PAD;
                     end else begin
                        resultReg <= DATA_W'(nextRem);
                        crcErrReg <= |nextRem;
                        keyErrReg <= 1'b0;
                        outValid  <= 1'b1;
                        state     <= DONE;
                     end
                  end else begin
                     bitCnt <= bitCnt + CNT_W'(1);
                  end
               end
            end
            PAD: begin
               remReg <= nextRem;
               if (bitCnt == LAST_PAD_BIT) begin
                  bitCnt    <= '0;
                  resultReg <= {dataReg[DATA_W-R-1:0], nextRem};
                  crcErrReg <= 1'b0;
                  keyErrReg <= 1'b0;
                  outValid  <= 1'b1;
                  state     <= DONE;
               end else begin
                  bitCnt <= bitCnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  outValid <= 1'b0;
                  inReady  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      in_ready  = inReady;
      out_valid = outValid;
      o         = resultReg;
      crc_err   = crcErrReg;
      key_err   = keyErrReg;
   end

endmodule

// File: tb/tb_alu_crc_seq.sv
// ----------------------------------------------------------------------------
// TbAluCrcSeq (module tb_alu_crc_seq)
//
// Bench for alu_crc_seq with DATA_W=32 and KEY_W=4.
// Known vectors are kept in a table. Hand-written sequences cover
// backpressure and reset aborts. Random requests are compared against a
// polynomial long-division model.
// ----------------------------------------------------------------------------
module tb_alu_crc_seq;

   localparam int DATA_W = 32;
   localparam int KEY_W  = 4;
   localparam int R      = KEY_W - 1;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] data;
   logic [KEY_W-1:0]  key;
   logic              funct;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] o;
   logic              crc_err;
   logic              key_err;

   int compared;
   int mismatched;

   typedef struct {
      logic [DATA_W-1:0] vData;
      logic [KEY_W-1:0]  vKey;
      logic              vFunct;
      logic [DATA_W-1:0] expO;
      logic              expCrc;
      logic              expKey;
      int                expLat;
   } vecT;

   alu_crc_seq #(.DATA_W(DATA_W), .KEY_W(KEY_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data      (data),
      .key       (key),
      .funct     (funct),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .crc_err   (crc_err),
      .key_err   (key_err)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net in case something stalls beyond every local bound.
   initial begin
      #3000000;
      $display("[TB] FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "[TB] global timeout");
   end

   // Polynomial remainder of an nbits-wide dividend over GF(2).
   // This is textbook long division on a 64-bit integer.
   function automatic logic [DATA_W-1:0] polyMod(input logic [63:0] dividend,
                                                 input int nbits,
                                                 input logic [KEY_W-1:0] k);
      logic [63:0] v;
      v = dividend;
      for (int i = nbits - 1; i >= R; i--) begin
         if (v[i]) v = v ^ (64'(k) << (i - R));
      end
      return DATA_W'(v & ((64'd1 << R) - 64'd1));
   endfunction

   // Expected behaviour of one request.
   task automatic model(input logic [DATA_W-1:0] d, input logic [KEY_W-1:0] k,
                        input logic f, output vecT v);
      logic [DATA_W-1:0] rem;
      v.vData  = d;
      v.vKey   = k;
      v.vFunct = f;
      if (!k[KEY_W-1]) begin
         v.expO = '0; v.expCrc = 1'b0; v.expKey = 1'b1; v.expLat = 1;
      end else if (!f) begin
         rem = polyMod({32'd0, d}, DATA_W, k);
         v.expO = rem; v.expCrc = (rem != 0); v.expKey = 1'b0; v.expLat = DATA_W;
      end else begin
         rem = polyMod(64'(d) << R, DATA_W + R, k);
         v.expO = (d << R) | rem; v.expCrc = 1'b0; v.expKey = 1'b0;
         v.expLat = DATA_W + R;
      end
   endtask

   // One comparison. Prints a line on mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Waits for in_ready, presents the request for one edge, then drives
   // junk inputs. This shows that the latched operands are the ones used.
   task automatic applyStimulus(input logic [DATA_W-1:0] d,
                                input logic [KEY_W-1:0] k, input logic f);
      int w;
      w = 0;
      while (!in_ready && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1; data = d; key = k; funct = f;
      @(posedge clk); #1;
      in_valid = 1'b0; data = $urandom; key = KEY_W'($urandom); funct = ~f;
   endtask

   // Counts edges from acceptance until out_valid, with a budget.
   // While busy, in_valid and out_ready toggle randomly. Both must be ignored.
   task automatic waitResult(output int lat);
      logic busyReady;
      busyReady = 1'b0;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = c;
            break;
         end
         if (in_ready) busyReady = 1'b1;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("in_ready_while_busy", 64'(busyReady), 64'd0);
   endtask

   task automatic checkResult(input string name, input vecT v, input int lat);
      checkOutput({name, "_o"}, 64'(o), 64'(v.expO));
      checkOutput({name, "_crc_err"}, 64'(crc_err), 64'(v.expCrc));
      checkOutput({name, "_key_err"}, 64'(key_err), 64'(v.expKey));
      checkOutput({name, "_latency"}, 64'(lat), 64'(v.expLat));
   endtask

   task automatic finishRequest(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({name, "_valid_after_hs"}, 64'(out_valid), 64'd0);
      checkOutput({name, "_ready_after_hs"}, 64'(in_ready), 64'd1);
   endtask

   task automatic runVector(input string name, input vecT v);
      int lat;
      applyStimulus(v.vData, v.vKey, v.vFunct);
      waitResult(lat);
      checkResult(name, v, lat);
      finishRequest(name);
   endtask

   // Asserts reset asynchronously in the middle of a cycle.
   // Checks the reset values, then releases reset and expects no stray result.
   task automatic resetAndWatch(input string name);
      logic anyValid;
      #2 rst = 1'b1;
      #1;
      checkOutput({name, "_rst_out_valid"}, 64'(out_valid), 64'd0);
      checkOutput({name, "_rst_in_ready"}, 64'(in_ready), 64'd0);
      checkOutput({name, "_rst_o"}, 64'(o), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput({name, "_rst_hold_in_ready"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput({name, "_ready_first_edge"}, 64'(in_ready), 64'd1);
      anyValid = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (out_valid) anyValid = 1'b1;
      end
      checkOutput({name, "_no_result"}, 64'(anyValid), 64'd0);
   endtask

   initial begin
      vecT table_v[10];
      vecT v;
      vecT good;
      int lat;
      int hold;
      logic [DATA_W-1:0] d;
      logic              stable;

      compared   = 0;
      mismatched = 0;

      // Fixed vectors: data, key, funct, o, crc_err, key_err, latency
      table_v[0] = '{32'h121, 4'hD, 1'b0, 32'h0, 1'b0, 1'b0, 32};
      table_v[1] = '{32'h24, 4'hD, 1'b1, 32'h121, 1'b0, 1'b0, 35};
      table_v[2] = '{32'h121, 4'hD, 1'b0, 32'h0, 1'b0, 1'b0, 32};
      table_v[3] = '{32'h123, 4'hD, 1'b0, 32'h2, 1'b1, 1'b0, 32};
      table_v[4] = '{32'hDEADBEEF, 4'h5, 1'b1, 32'h0, 1'b0, 1'b1, 1};
      table_v[5] = '{32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1};
      table_v[6] = '{32'h0, 4'hD, 1'b1, 32'h0, 1'b0, 1'b0, 35};
      table_v[7] = '{32'hD, 4'hD, 1'b0, 32'h0, 1'b0, 1'b0, 32};
      table_v[8] = '{32'h1, 4'h8, 1'b0, 32'h1, 1'b1, 1'b0, 32};
      table_v[9] = '{32'h7, 4'h9, 1'b1, 32'h3F, 1'b0, 1'b0, 35};
      good       = '{32'h121, 4'hD, 1'b0, 32'h0, 1'b0, 1'b0, 32};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      data = '0; key = '0; funct = 1'b0;

      // Values while reset is held, including across clock edges.
      #3;
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      checkOutput("reset_o", 64'(o), 64'd0);
      checkOutput("reset_errs", 64'({crc_err, key_err}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready_after_release", 64'(in_ready), 64'd1);

      $display("[TB] table vectors");
      foreach (table_v[i]) begin
         runVector($sformatf("vec%0d", i), table_v[i]);
      end

      // Backpressure. The result must stay stable and in_ready must stay low.
      // A waiting request must not be accepted on the handshake edge.
      $display("[TB] backpressure sequence");
      model(32'h123, 4'hD, 1'b0, v);
      applyStimulus(v.vData, v.vKey, v.vFunct);
      waitResult(lat);
      checkResult("bp", v, lat);
      in_valid = 1'b1; data = 32'h121; key = 4'hD; funct = 1'b0;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (o !== 32'h2 || crc_err !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1)
            stable = 1'b0;
      end
      checkOutput("bp_hold_stable", 64'(stable), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
      checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
      applyStimulus(32'h121, 4'hD, 1'b0);
      waitResult(lat);
      checkResult("bp_next", good, lat);
      finishRequest("bp_next");

      // Reset in the middle of SHIFT, in PAD and in DONE.
      $display("[TB] reset abort sequences");
      applyStimulus(32'h121, 4'hD, 1'b0);
      repeat (14) @(posedge clk);
      resetAndWatch("abort_shift");
      runVector("after_shift_abort", good);

      applyStimulus(32'h24, 4'hD, 1'b1);
      repeat (32) @(posedge clk);
      resetAndWatch("abort_pad");
      runVector("after_pad_abort", good);

      model(32'h123, 4'hD, 1'b0, v);
      applyStimulus(v.vData, v.vKey, v.vFunct);
      waitResult(lat);
      checkResult("pre_done_abort", v, lat);
      resetAndWatch("abort_done");
      runVector("after_done_abort", good);

      // Random requests compared against the division model.
      $display("[TB] random requests");
      for (int n = 0; n < 60; n++) begin
         d = $urandom;
         d = d >> $urandom_range(0, 31);
         model(d, KEY_W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), v);
         applyStimulus(v.vData, v.vKey, v.vFunct);
         waitResult(lat);
         hold = $urandom_range(0, 3);
         repeat (hold) begin
            @(posedge clk); #1;
         end
         checkResult($sformatf("rnd%0d", n), v, lat);
         finishRequest($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
